// File: rtl/scx_pkg.sv
// Shared types and constants for the SCx slave-core stage behind the Core-B Lite wrapper.
package scx_pkg;

    localparam int unsigned SCX_DW  = 39;
    localparam int unsigned SCX_BEW = 4;
    localparam int unsigned WS_CW   = 4;
    localparam int unsigned TO_CW   = 10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARB      = 3'd1,
        ST_RDCAP    = 3'd2,
        ST_WS       = 3'd3,
        ST_RESP_ERR = 3'd4,
        ST_RESP_TO  = 3'd5
    } scx_state_t;

    localparam logic [1:0] FLT_NONE    = 2'd0;
    localparam logic [1:0] FLT_RANGE   = 2'd1;
    localparam logic [1:0] FLT_BE      = 2'd2;
    localparam logic [1:0] FLT_TIMEOUT = 2'd3;

    // Transfer-size and lane encodings agreed with the wrapper
    localparam logic [1:0] MMSZ_BYTE = 2'b00;
    localparam logic [1:0] MMSZ_HALF = 2'b01;
    localparam logic [1:0] MMSZ_WORD = 2'b10;

    localparam logic [SCX_BEW-1:0] BE_NONE    = 4'b0000;
    localparam logic [SCX_BEW-1:0] BE_HALF_LO = 4'b0011;
    localparam logic [SCX_BEW-1:0] BE_HALF_HI = 4'b1100;
    localparam logic [SCX_BEW-1:0] BE_WORD    = 4'b1111;

    typedef struct packed {
        logic                  wt;
        logic [SCX_BEW-1:0]    be;
        logic [SCX_DW-1:0]     wdt;
    } scx_cmd_t;

    function automatic logic [1:0] scx_fault_code(input logic addr_oob, input logic [SCX_BEW-1:0] be);
        logic [1:0] code;
        code = FLT_NONE;
        if (addr_oob) begin
            code = FLT_RANGE;
        end else if (be == BE_NONE) begin
            code = FLT_BE;
        end
        return code;
    endfunction

endpackage

// File: rtl/scx_sram_core_wait_cnt.sv
// Loadable down-counter with zero flag that paces the wait-state phase.
module scx_wait_cnt
    import scx_pkg::*;
(
    input  logic             CLK,
    input  logic             nRST,
    input  logic             load,
    input  logic [WS_CW-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WS_CW-1:0] cnt_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WS_CW'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/scx_sram_core.sv
// SCx slave core: accepts wrapper requests, arbitrates for a shared single-port SRAM,
// and adds wait states, fault checking and a grant-timeout watchdog.
module scx_sram_core
    import scx_pkg::*;
#(
    parameter int unsigned AW       = 12,
    parameter int unsigned RD_WS    = 0,
    parameter int unsigned WR_WS    = 0,
    parameter int unsigned TO_LIMIT = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              SCx_REQ,
    input  logic              SCx_WT,
    input  logic [3:0]        SCx_BE,
    input  logic [31:0]       SCx_ADDR,
    input  logic [SCX_DW-1:0] SCx_WDT,
    output logic [SCX_DW-1:0] SCx_RDT,
    output logic              SCx_nWAIT,
    output logic              SCx_FAULT,
    output logic              SCx_TimeOut,
    output logic              MEM_REQ,
    input  logic              MEM_GNT,
    output logic              MEM_CSn,
    output logic              MEM_WEn,
    output logic [3:0]        MEM_BE,
    output logic [AW-1:0]     MEM_A,
    output logic [SCX_DW-1:0] MEM_D,
    input  logic [SCX_DW-1:0] MEM_Q
);

    localparam logic [TO_CW-1:0] TO_LAST = TO_CW'(TO_LIMIT - 1);
    // The read-capture cycle already counts as the first read wait cycle
    localparam logic [WS_CW-1:0] RD_LOAD = (RD_WS >= 2) ? WS_CW'(RD_WS - 2) : '0;
    localparam logic [WS_CW-1:0] WR_LOAD = (WR_WS >= 1) ? WS_CW'(WR_WS - 1) : '0;

    scx_state_t        state_q, state_d;
    scx_cmd_t          cmd_q;
    logic [AW-1:0]     addr_q;
    logic [TO_CW-1:0]  to_cnt_q, to_cnt_d;
    logic [SCX_DW-1:0] rdt_q;
    logic              accept;
    logic              bad_cmd;
    logic              ws_load, ws_dec, ws_zero;
    logic [WS_CW-1:0]  ws_load_val;
    logic              addr_lo_unused;

    assign bad_cmd        = (scx_fault_code(|SCx_ADDR[31:AW+2], SCx_BE) != FLT_NONE);
    assign addr_lo_unused = ^SCx_ADDR[1:0];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            addr_q   <= '0;
            to_cnt_q <= '0;
            rdt_q    <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            if (accept) begin
                cmd_q.wt  <= SCx_WT;
                cmd_q.be  <= SCx_BE;
                cmd_q.wdt <= SCx_WDT;
                addr_q    <= SCx_ADDR[AW+1:2];
            end
            if (state_q == ST_RDCAP) begin
                rdt_q <= MEM_Q;
            end
        end
    end

    // Next-state and the strobes decoded from the current state and grant
    always_comb begin
        state_d     = state_q;
        to_cnt_d    = '0;
        accept      = 1'b0;
        ws_load     = 1'b0;
        ws_load_val = '0;
        ws_dec      = 1'b0;
        SCx_nWAIT   = 1'b1;
        SCx_FAULT   = 1'b0;
        SCx_TimeOut = 1'b0;
        MEM_REQ     = 1'b0;
        MEM_CSn     = 1'b1;
        MEM_WEn     = 1'b1;
        MEM_BE      = '0;

        case (state_q)
            ST_IDLE: begin
                if (SCx_REQ) begin
                    accept  = 1'b1;
                    state_d = bad_cmd ? ST_RESP_ERR : ST_ARB;
                end
            end
            ST_ARB: begin
                MEM_REQ   = 1'b1;
                SCx_nWAIT = 1'b0;
                if (MEM_GNT) begin
                    MEM_CSn = 1'b0;
                    MEM_WEn = ~cmd_q.wt;
                    MEM_BE  = cmd_q.wt ? cmd_q.be : '0;
                    if (cmd_q.wt) begin
                        // A strobed write is complete; only the post-write gap remains
                        SCx_nWAIT = 1'b1;
                        if (WR_WS == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            ws_load     = 1'b1;
                            ws_load_val = WR_LOAD;
                            state_d     = ST_WS;
                        end
                    end else begin
                        state_d = ST_RDCAP;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = ST_RESP_TO;
                end else begin
                    to_cnt_d = to_cnt_q + TO_CW'(1);
                end
            end
            ST_RDCAP: begin
                SCx_nWAIT = (RD_WS == 0);
                if (RD_WS >= 2) begin
                    ws_load     = 1'b1;
                    ws_load_val = RD_LOAD;
                    state_d     = ST_WS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WS: begin
                SCx_nWAIT = 1'b0;
                if (ws_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    ws_dec = 1'b1;
                end
            end
            ST_RESP_ERR: begin
                SCx_FAULT = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_RESP_TO: begin
                SCx_FAULT   = 1'b1;
                SCx_TimeOut = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    scx_wait_cnt u_wait_cnt (
        .CLK      (CLK),
        .nRST     (nRST),
        .load     (ws_load),
        .load_val (ws_load_val),
        .dec      (ws_dec),
        .zero     (ws_zero)
    );

    assign SCx_RDT = rdt_q;
    assign MEM_A   = addr_q;
    assign MEM_D   = cmd_q.wdt;

endmodule

// File: tb/tb_scx_sram_core.sv
// Bench for scx_sram_core: two instances with different wait-state settings, each with
// its own SRAM model, checked transaction by transaction against a reference memory.
module tb_scx_sram_core;
    import scx_pkg::*;

    localparam int unsigned AW     = 12;
    localparam int unsigned DEPTH  = 1 << AW;
    localparam int unsigned TO_LIM = 8;

    int tests = 0;
    int fails = 0;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic preload = 1'b0;

    logic              req  [2];
    logic              wt   [2];
    logic              gnt  [2];
    logic [3:0]        be   [2];
    logic [31:0]       addr [2];
    logic [SCX_DW-1:0] wdt  [2];
    logic [SCX_DW-1:0] rdt  [2];
    logic              nwait[2];
    logic              fault[2];
    logic              tmo  [2];
    logic              mreq [2];
    logic              csn  [2];
    logic              wen  [2];
    logic [3:0]        mbe  [2];
    logic [AW-1:0]     ma   [2];
    logic [SCX_DW-1:0] md   [2];
    logic [SCX_DW-1:0] mq   [2];
    logic [SCX_DW-1:0] sram [2][DEPTH];
    logic [SCX_DW-1:0] refm [2][DEPTH];

    always #5 CLK = ~CLK;

    function automatic int unsigned rdws(input int s);
        return (s == 0) ? 32'd0 : 32'd1;
    endfunction

    function automatic int unsigned wrws(input int s);
        return (s == 0) ? 32'd2 : 32'd0;
    endfunction

    function automatic logic [SCX_DW-1:0] seed_word(input int i);
        if (i == 5) return 39'h0DEADBEEF;
        return {7'(i * 3), 32'(i) * 32'h9E3779B1};
    endfunction

    scx_sram_core #(.AW(AW), .RD_WS(0), .WR_WS(2), .TO_LIMIT(TO_LIM)) dut_a (
        .CLK(CLK), .nRST(nRST),
        .SCx_REQ(req[0]), .SCx_WT(wt[0]), .SCx_BE(be[0]), .SCx_ADDR(addr[0]), .SCx_WDT(wdt[0]),
        .SCx_RDT(rdt[0]), .SCx_nWAIT(nwait[0]), .SCx_FAULT(fault[0]), .SCx_TimeOut(tmo[0]),
        .MEM_REQ(mreq[0]), .MEM_GNT(gnt[0]), .MEM_CSn(csn[0]), .MEM_WEn(wen[0]),
        .MEM_BE(mbe[0]), .MEM_A(ma[0]), .MEM_D(md[0]), .MEM_Q(mq[0])
    );

    scx_sram_core #(.AW(AW), .RD_WS(1), .WR_WS(0), .TO_LIMIT(TO_LIM)) dut_b (
        .CLK(CLK), .nRST(nRST),
        .SCx_REQ(req[1]), .SCx_WT(wt[1]), .SCx_BE(be[1]), .SCx_ADDR(addr[1]), .SCx_WDT(wdt[1]),
        .SCx_RDT(rdt[1]), .SCx_nWAIT(nwait[1]), .SCx_FAULT(fault[1]), .SCx_TimeOut(tmo[1]),
        .MEM_REQ(mreq[1]), .MEM_GNT(gnt[1]), .MEM_CSn(csn[1]), .MEM_WEn(wen[1]),
        .MEM_BE(mbe[1]), .MEM_A(ma[1]), .MEM_D(md[1]), .MEM_Q(mq[1])
    );

    // Single-port SRAM: byte-masked data lanes, check bits follow every write
    for (genvar g = 0; g < 2; g++) begin : g_sram
        always @(posedge CLK) begin
            if (preload) begin
                for (int i = 0; i < DEPTH; i++) sram[g][i] <= seed_word(i);
            end else if (!csn[g]) begin
                if (!wen[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (mbe[g][b]) sram[g][ma[g]][8*b +: 8] <= md[g][8*b +: 8];
                    sram[g][ma[g]][38:32] <= md[g][38:32];
                end
                mq[g] <= sram[g][ma[g]];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input int s);
        check("rst_nwait", 64'(nwait[s]), 64'd1);
        check("rst_fault", 64'(fault[s]), 64'd0);
        check("rst_tmo",   64'(tmo[s]),   64'd0);
        check("rst_rdt",   64'(rdt[s]),   64'd0);
        check("rst_mreq",  64'(mreq[s]),  64'd0);
        check("rst_csn",   64'(csn[s]),   64'd1);
        check("rst_wen",   64'(wen[s]),   64'd1);
        check("rst_mbe",   64'(mbe[s]),   64'd0);
        check("rst_ma",    64'(ma[s]),    64'd0);
        check("rst_md",    64'(md[s]),    64'd0);
    endtask

    // One wrapper transaction; grant is withheld for the first d arbitration cycles
    task automatic txn(input int s, input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [SCX_DW-1:0] dat, input int unsigned d);
        logic bad, tout, fault_nw, tout_req, s_we, nw_cap;
        int unsigned word, win, stall, strobes, nfault, ntout;
        logic [3:0] s_be;
        logic [AW-1:0] s_a;
        logic [SCX_DW-1:0] s_d, rd_at, rdt_before;
        bad  = (a[31:AW+2] != '0) || (b == 4'b0);
        tout = !bad && (d >= TO_LIM);
        word = 32'(a[AW+1:2]);
        win  = d + TO_LIM + 8;
        stall = 0; strobes = 0; nfault = 0; ntout = 0;
        fault_nw = 1'b0; tout_req = 1'b1; s_we = 1'b1; nw_cap = 1'b0;
        s_be = '0; s_a = '0; s_d = '0; rd_at = '0;

        @(negedge CLK);
        req[s] = 1'b1; wt[s] = w; be[s] = b; addr[s] = a; wdt[s] = dat; gnt[s] = 1'b0;
        #1;
        rdt_before = rdt[s];
        check("accept_nwait", 64'(nwait[s]), 64'd1);
        @(negedge CLK);
        req[s] = 1'b0; be[s] = 4'($urandom); addr[s] = $urandom; wdt[s] = {7'd0, $urandom};
        for (int k = 0; k < int'(win); k++) begin
            gnt[s] = (k >= int'(d));
            #1;
            if (!nwait[s]) stall++;
            if (fault[s]) begin nfault++; fault_nw = nwait[s]; end
            if (tmo[s]) begin ntout++; tout_req = mreq[s]; end
            if (!csn[s]) begin strobes++; s_a = ma[s]; s_we = wen[s]; s_be = mbe[s]; s_d = md[s]; end
            if (k == int'(d) + 1) nw_cap = nwait[s];
            if (k == int'(d) + 2) rd_at = rdt[s];
            @(negedge CLK);
        end
        gnt[s] = 1'b0;

        if (bad || tout) begin
            check("flt_strobes", 64'(strobes), 64'd0);
            check("flt_pulses",  64'(nfault), 64'd1);
            check("flt_nwait",   64'(fault_nw), 64'd1);
            check("to_pulses",   64'(ntout), 64'(tout));
            check("flt_stall",   64'(stall), tout ? 64'(TO_LIM) : 64'd0);
            if (tout) check("to_mreq", 64'(tout_req), 64'd0);
            check("flt_rdt_held", 64'(rdt[s]), 64'(rdt_before));
        end else begin
            check("strobes",  64'(strobes), 64'd1);
            check("mem_addr", 64'(s_a), 64'(word));
            check("no_fault", 64'(nfault + ntout), 64'd0);
            check("mem_wen",  64'(s_we), 64'(!w));
            if (w) begin
                check("wr_be",       64'(s_be), 64'(b));
                check("wr_data",     64'(s_d), 64'(dat));
                check("wr_stall",    64'(stall), 64'(d + wrws(s)));
                check("wr_rdt_held", 64'(rdt[s]), 64'(rdt_before));
                for (int l = 0; l < 4; l++)
                    if (b[l]) refm[s][word][8*l +: 8] = dat[8*l +: 8];
                refm[s][word][38:32] = dat[38:32];
            end else begin
                check("rd_be",        64'(s_be), 64'd0);
                check("rd_stall",     64'(stall), 64'(d + 1 + rdws(s)));
                check("rd_cap_nwait", 64'(nw_cap), 64'(rdws(s) == 0));
                check("rd_data",      64'(rd_at), 64'(refm[s][word]));
                check("rd_held",      64'(rdt[s]), 64'(refm[s][word]));
            end
        end
    endtask

    initial begin
        int s_r;
        logic w_r;
        logic [3:0] b_r;
        logic [31:0] a_r;
        logic [SCX_DW-1:0] wv;
        logic [SCX_DW-1:0] seed2;
        int unsigned d_r;

        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b0; wt[s] = 1'b0; gnt[s] = 1'b0; be[s] = '0; addr[s] = '0; wdt[s] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            refm[0][i] = seed_word(i);
            refm[1][i] = seed_word(i);
        end
        preload = 1'b1;
        repeat (3) @(negedge CLK);
        preload = 1'b0;
        #1;
        check_reset(0);
        check_reset(1);
        @(negedge CLK);
        nRST = 1'b1;

        // Directed: read of preloaded word 5, then lane-2 write and readback
        txn(0, 1'b0, 4'b1111, 32'h14, '0, 0);
        check("rd_deadbeef", 64'(rdt[0]), 64'h0DEADBEEF);
        txn(0, 1'b1, 4'b0100, 32'h8, 39'h000AA0000, 0);
        txn(0, 1'b0, 4'b1111, 32'h8, '0, 0);
        seed2 = seed_word(2);
        check("wr_lane2", 64'(rdt[0][23:16]), 64'hAA);
        check("wr_lanes_kept", 64'({rdt[0][31:24], rdt[0][15:0]}), 64'({seed2[31:24], seed2[15:0]}));

        // Faults, then a normal access; timeout; late grant with one read wait state
        txn(0, 1'b0, 4'b1111, 32'h4000, '0, 0);
        txn(0, 1'b1, 4'b0000, 32'h10, 39'h123, 0);
        txn(0, 1'b0, 4'b1111, 32'h14, '0, 0);
        txn(0, 1'b0, 4'b1111, 32'h20, '0, TO_LIM + 20);
        txn(1, 1'b0, 4'b1111, 32'h14, '0, 3);
        txn(1, 1'b1, 4'b1001, 32'h30, 39'h7F_11223344, 2);
        txn(1, 1'b0, 4'b1111, 32'h30, '0, 0);

        // Randomized transactions over a small address window to get read-after-write hits
        for (int n = 0; n < 60; n++) begin
            s_r = n % 2;
            w_r = 1'($urandom_range(0, 1));
            b_r = ($urandom_range(0, 9) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
            a_r = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a_r = a_r | (32'd1 << $urandom_range(AW + 2, 31));
            d_r = ($urandom_range(0, 14) == 0) ? TO_LIM + 20 : $urandom_range(0, 3);
            wv  = {7'($urandom), $urandom};
            txn(s_r, w_r, b_r, a_r, wv, d_r);
        end

        // Asynchronous reset while the write wait states are running
        wv = 39'h55_CAFEF00D;
        @(negedge CLK);
        req[0] = 1'b1; wt[0] = 1'b1; be[0] = 4'b1111; addr[0] = 32'h40; wdt[0] = wv; gnt[0] = 1'b1;
        @(negedge CLK);
        req[0] = 1'b0;
        #1;
        check("mid_strobe", 64'(csn[0]), 64'd0);
        @(posedge CLK);
        #2;
        check("mid_ws_nwait", 64'(nwait[0]), 64'd0);
        nRST = 1'b0;
        #1;
        check_reset(0);
        refm[0][16] = wv;
        gnt[0] = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        txn(0, 1'b0, 4'b1111, 32'h40, '0, 0);
        check("post_rst_rd", 64'(rdt[0]), 64'(wv));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
